// File: rtl/core_pkg.sv
// Shared RV32IM core types and constants: word width, NOP encoding, reset PC
// and the fetch-buffer entry.
package core_pkg;

  localparam int              XLEN             = 32;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// 2-entry FIFO of fetch entries; push and pop may coincide, head is registered (0-cycle read).
// Flush empties the FIFO, but a push in the flush cycle still lands as the new head.
module fetch_buf
  import core_pkg::*;
#(
  parameter fetch_entry_t RST_ENTRY = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_dat_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);

  fetch_entry_t mem_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;
  logic         wr_sel;

  assign wr_sel = flush_i ? 1'b0 : wr_ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= RST_ENTRY;
      mem_q[1] <= RST_ENTRY;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) mem_q[wr_sel] <= push_dat_i;
      if (flush_i) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= push_i;
        count_q  <= {1'b0, push_i};
      end else begin
        if (push_i) wr_ptr_q <= ~wr_ptr_q;
        if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
        count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
      end
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues word fetches (<=2 in flight+buffered), 2-cycle min fetch-to-decode.
// Redirects flush and drop wrong-path words; FETCH_MISALIGN_TRAP_EN turns misaligned targets into a faulting halt.
module instr_fetch
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC        = DEFAULT_RESET_PC,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            if_fault
);

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam fetch_entry_t RST_ENTRY = '{instr: NOP_INSTR, pc: RESET_PC, fault: 1'b0};

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]      in_flight_q, in_flight_d;
  logic [1:0]      drop_q, drop_d;
  logic            halt_q, halt_d;
  logic            run_q;
  logic [XLEN-1:0] pcq_q [2];
  logic            pcq_wr_q, pcq_rd_q;

  logic [1:0]      buf_count;
  fetch_entry_t    buf_head, push_dat;
  logic            push, pop, req_fire, misalign;
  logic [XLEN-1:0] redir_tgt;
  logic [2:0]      credit_used;

  assign pop      = if_valid & if_ready;
  assign req_fire = imem_req_valid & imem_req_ready;
  assign misalign = TRAP_EN & redirect_valid & (redirect_pc[1:0] != 2'b00);
  assign redir_tgt = TRAP_EN ? redirect_pc : {redirect_pc[XLEN-1:2], 2'b00};

  // A word popped this cycle returns its credit at once so a ready decode gets one word per cycle.
  assign credit_used    = {1'b0, in_flight_q} + {1'b0, buf_count} - {2'b00, pop};
  assign imem_req_valid = run_q & ~halt_q & (credit_used < 3'(MAX_OUTSTANDING));
  assign imem_addr      = fetch_pc_q;

  always_comb begin
    push     = 1'b0;
    push_dat = RST_ENTRY;
    if (misalign) begin
      push     = 1'b1;
      push_dat = '{instr: NOP_INSTR, pc: redirect_pc, fault: 1'b1};
    end else if (imem_rsp_valid && !redirect_valid && drop_q == 2'd0) begin
      push     = 1'b1;
      push_dat = '{instr: imem_rdata, pc: pcq_q[pcq_rd_q], fault: 1'b0};
    end
  end

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    halt_d      = halt_q;
    in_flight_d = in_flight_q + {1'b0, req_fire} - {1'b0, imem_rsp_valid};
    drop_d      = drop_q;
    if (imem_rsp_valid && drop_q != 2'd0) drop_d = drop_q - 2'd1;
    if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
    // Everything still outstanding after this cycle, including a same-cycle accept, is wrong-path.
    if (redirect_valid) begin
      fetch_pc_d = redir_tgt;
      halt_d     = misalign;
      drop_d     = in_flight_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q  <= RESET_PC;
      in_flight_q <= 2'd0;
      drop_q      <= 2'd0;
      halt_q      <= 1'b0;
      run_q       <= 1'b0;
      pcq_q[0]    <= '0;
      pcq_q[1]    <= '0;
      pcq_wr_q    <= 1'b0;
      pcq_rd_q    <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      in_flight_q <= in_flight_d;
      drop_q      <= drop_d;
      halt_q      <= halt_d;
      run_q       <= 1'b1;
      if (req_fire) begin
        pcq_q[pcq_wr_q] <= fetch_pc_q;
        pcq_wr_q        <= ~pcq_wr_q;
      end
      if (imem_rsp_valid) pcq_rd_q <= ~pcq_rd_q;
    end
  end

  fetch_buf #(
    .RST_ENTRY(RST_ENTRY)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (redirect_valid),
    .push_i    (push),
    .push_dat_i(push_dat),
    .pop_i     (pop),
    .head_o    (buf_head),
    .count_o   (buf_count)
  );

  assign if_valid = (buf_count != 2'd0);
  assign if_instr = buf_head.instr;
  assign if_pc    = buf_head.pc;
  assign if_fault = TRAP_EN ? buf_head.fault : 1'b0;

endmodule

// File: tb/tb_instr_fetch.sv
// Cycle-table bench for instr_fetch with an in-order memory model of configurable latency,
// plus a second instance checking PC wrap from 32'hFFFF_FFFC.
`timescale 1ns/1ps
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        rv;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] pc;
    logic        flt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic        imem_rsp_valid;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid, if_ready, if_fault;
  logic [31:0] if_instr, if_pc;

  logic        w_req_valid, w_req_ready, w_rsp_valid, w_redir, w_if_valid, w_if_ready, w_if_fault;
  logic [31:0] w_addr, w_rdata, w_redir_pc, w_if_instr, w_if_pc;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] q_addr[$];
  int          q_due[$];
  vec_t        stream_tbl[14];

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc), .if_fault(if_fault)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_addr(w_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rdata(w_rdata),
    .redirect_valid(w_redir), .redirect_pc(w_redir_pc),
    .if_valid(w_if_valid), .if_ready(w_if_ready), .if_instr(w_if_instr), .if_pc(w_if_pc), .if_fault(w_if_fault)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic vec_t V(input logic rdy, input logic redir, input logic [31:0] rpc,
                             input logic rv, input logic [31:0] addr,
                             input logic iv, input logic [31:0] pc, input logic flt);
    vec_t v;
    v.rdy = rdy; v.redir = redir; v.rpc = rpc; v.rv = rv; v.addr = addr;
    v.iv = iv; v.pc = pc; v.flt = flt;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    if_ready = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rdata = '0;
    q_addr.delete();
    q_due.delete();
    #1;
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_if_valid", {31'b0, if_valid}, 32'd0);
    check("rst_if_instr", if_instr, NOP);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_fault", {31'b0, if_fault}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = -1;
    #1;
    check("rel_req_valid", {31'b0, imem_req_valid}, 32'd0);
  endtask

  task automatic step(input string nm, input int idx, input vec_t v);
    @(negedge clk);
    cyc++;
    if_ready = v.rdy;
    redirect_valid = v.redir;
    redirect_pc = v.rpc;
    if (q_addr.size() > 0 && q_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rdata = mem_word(q_addr[0]);
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rdata = '0;
    end
    #1;
    if (imem_req_valid && imem_req_ready) begin
      q_addr.push_back(imem_addr);
      q_due.push_back(cyc + lat);
    end
    check($sformatf("%s[%0d].req_valid", nm, idx), {31'b0, imem_req_valid}, {31'b0, v.rv});
    if (v.rv) check($sformatf("%s[%0d].imem_addr", nm, idx), imem_addr, v.addr);
    check($sformatf("%s[%0d].if_valid", nm, idx), {31'b0, if_valid}, {31'b0, v.iv});
    if (v.iv) begin
      check($sformatf("%s[%0d].if_pc", nm, idx), if_pc, v.pc);
      check($sformatf("%s[%0d].if_instr", nm, idx), if_instr, v.flt ? NOP : mem_word(v.pc));
      check($sformatf("%s[%0d].if_fault", nm, idx), {31'b0, if_fault}, {31'b0, v.flt});
    end
  endtask

  initial begin
    w_req_ready = 1'b1; w_rsp_valid = 1'b0; w_rdata = '0;
    w_redir = 1'b0; w_redir_pc = '0; w_if_ready = 1'b1;

    // reset, stream at one word per cycle, then a 5-cycle decode stall (cycles 5..9)
    stream_tbl[0]  = V(1, 0, 0, 1, 32'h00, 0, 0,     0);
    stream_tbl[1]  = V(1, 0, 0, 1, 32'h04, 0, 0,     0);
    stream_tbl[2]  = V(1, 0, 0, 1, 32'h08, 1, 32'h0, 0);
    stream_tbl[3]  = V(1, 0, 0, 1, 32'h0C, 1, 32'h4, 0);
    stream_tbl[4]  = V(1, 0, 0, 1, 32'h10, 1, 32'h8, 0);
    stream_tbl[5]  = V(0, 0, 0, 0, 32'h00, 1, 32'hC, 0);
    stream_tbl[6]  = V(0, 0, 0, 0, 32'h00, 1, 32'hC, 0);
    stream_tbl[7]  = V(0, 0, 0, 0, 32'h00, 1, 32'hC, 0);
    stream_tbl[8]  = V(0, 0, 0, 0, 32'h00, 1, 32'hC, 0);
    stream_tbl[9]  = V(0, 0, 0, 0, 32'h00, 1, 32'hC, 0);
    stream_tbl[10] = V(1, 0, 0, 1, 32'h14, 1, 32'hC, 0);
    stream_tbl[11] = V(1, 0, 0, 1, 32'h18, 1, 32'h10, 0);
    stream_tbl[12] = V(1, 0, 0, 1, 32'h1C, 1, 32'h14, 0);
    stream_tbl[13] = V(1, 0, 0, 1, 32'h20, 1, 32'h18, 0);

    lat = 1;
    do_reset();
    check("wrap_rst_addr", w_addr, 32'hFFFF_FFFC);
    for (int i = 0; i < 14; i++) begin
      step("stream", i, stream_tbl[i]);
      if (i == 0) check("wrap_addr0", w_addr, 32'hFFFF_FFFC);
      if (i == 1) check("wrap_addr1", w_addr, 32'h0000_0000);
      if (i < 2)  check($sformatf("wrap_valid%0d", i), {31'b0, w_req_valid}, 32'd1);
    end

    // redirect to 0x100 with two 3-cycle requests outstanding
    lat = 3;
    do_reset();
    step("redir", 0, V(1, 0, 0,      1, 32'h000, 0, 0, 0));
    step("redir", 1, V(1, 0, 0,      1, 32'h004, 0, 0, 0));
    step("redir", 2, V(1, 1, 32'h100, 0, 32'h000, 0, 0, 0));
    step("redir", 3, V(1, 0, 0,      0, 32'h000, 0, 0, 0));
    step("redir", 4, V(1, 0, 0,      1, 32'h100, 0, 0, 0));
    step("redir", 5, V(1, 0, 0,      1, 32'h104, 0, 0, 0));
    step("redir", 6, V(1, 0, 0,      0, 32'h000, 0, 0, 0));
    step("redir", 7, V(1, 0, 0,      0, 32'h000, 0, 0, 0));
    step("redir", 8, V(1, 0, 0,      1, 32'h108, 1, 32'h100, 0));
    step("redir", 9, V(1, 0, 0,      1, 32'h10C, 1, 32'h104, 0));

    // redirect coinciding with a response and a pop
    lat = 1;
    do_reset();
    step("simul", 0, V(1, 0, 0,      1, 32'h000, 0, 0, 0));
    step("simul", 1, V(1, 0, 0,      1, 32'h004, 0, 0, 0));
    step("simul", 2, V(1, 0, 0,      1, 32'h008, 1, 32'h0, 0));
    step("simul", 3, V(1, 1, 32'h200, 1, 32'h00C, 1, 32'h4, 0));
    step("simul", 4, V(1, 0, 0,      1, 32'h200, 0, 0, 0));
    step("simul", 5, V(1, 0, 0,      1, 32'h204, 0, 0, 0));
    step("simul", 6, V(1, 0, 0,      1, 32'h208, 1, 32'h200, 0));
    step("simul", 7, V(1, 0, 0,      1, 32'h20C, 1, 32'h204, 0));

    // misaligned redirect target 0x102
    do_reset();
    step("misal", 0, V(1, 0, 0,      1, 32'h000, 0, 0, 0));
    step("misal", 1, V(1, 0, 0,      1, 32'h004, 0, 0, 0));
    step("misal", 2, V(1, 1, 32'h102, 1, 32'h008, 1, 32'h0, 0));
`ifdef FETCH_MISALIGN_TRAP_EN
    step("misal", 3, V(0, 0, 0,      0, 32'h000, 1, 32'h102, 1));
    step("misal", 4, V(0, 0, 0,      0, 32'h000, 1, 32'h102, 1));
    step("misal", 5, V(1, 1, 32'h300, 0, 32'h000, 1, 32'h102, 1));
    step("misal", 6, V(1, 0, 0,      1, 32'h300, 0, 0, 0));
    step("misal", 7, V(1, 0, 0,      1, 32'h304, 0, 0, 0));
    step("misal", 8, V(1, 0, 0,      1, 32'h308, 1, 32'h300, 0));
`else
    step("misal", 3, V(1, 0, 0,      1, 32'h100, 0, 0, 0));
    step("misal", 4, V(1, 0, 0,      1, 32'h104, 0, 0, 0));
    step("misal", 5, V(1, 0, 0,      1, 32'h108, 1, 32'h100, 0));
    step("misal", 6, V(1, 0, 0,      1, 32'h10C, 1, 32'h104, 0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
